// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage pipeline.
package cpu_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_BYTE, WB_PC} wb_sel_t;

  // PC-save wins over a load; a byte load narrows the memory result.
  function automatic wb_sel_t wb_select(input logic pcs, input logic memtoreg,
                                        input logic load_byte);
    if (pcs)                        return WB_PC;
    else if (memtoreg && load_byte) return WB_BYTE;
    else if (memtoreg)              return WB_MEM;
    else                            return WB_ALU;
  endfunction
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB boundary register; a bubble clears the control and data fields.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bubble,
  input  logic [REG_ADDR_W-1:0] d_dest,
  input  logic [WORD_W-1:0]     d_wdata,
  input  logic                  d_regwrite,
  input  logic                  d_hlt,
  output logic [REG_ADDR_W-1:0] W_Destination,
  output logic [WORD_W-1:0]     W_WriteData,
  output logic                  W_RegWrite,
  output logic                  W_hlt
);
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  regwrite_q, regwrite_d;
  logic                  hlt_q, hlt_d;

  always_comb begin
    dest_d     = d_dest;
    wdata_d    = d_wdata;
    regwrite_d = d_regwrite;
    hlt_d      = d_hlt;
    if (bubble) begin
      dest_d     = '0;
      wdata_d    = '0;
      regwrite_d = 1'b0;
      hlt_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dest_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      dest_q     <= dest_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      hlt_q      <= hlt_d;
    end
  end

  assign W_Destination = dest_q;
  assign W_WriteData   = wdata_q;
  assign W_RegWrite    = regwrite_q;
  assign W_hlt         = hlt_q;
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: req/ack data-memory access, stall, writeback select.
// Optional DMEM_TIMEOUT_EN forces completion of an unanswered access.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] M_Destination,
  input  logic [WORD_W-1:0]     M_ALUout,
  input  logic [WORD_W-1:0]     M_WriteData,
  input  logic [WORD_W-1:0]     M_Nxt_Pc,
  input  logic                  M_hlt,
  input  logic                  M_MemtoReg,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic                  M_RegWrite,
  input  logic                  M_Pcs,
  input  logic                  M_load_byte,
  input  logic                  M_sw,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic [WORD_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] W_Destination,
  output logic [WORD_W-1:0]     W_WriteData,
  output logic                  W_RegWrite,
  output logic                  W_hlt,
  output logic                  dmem_err
);
  state_t              state_q, state_d;
  logic                mem_op, done, timeout, regwrite;
  logic [WORD_W-1:0]   rdata_eff, wb_val;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(DMEM_TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter idles at zero, so it is already cleared when WAIT is entered.
  always_comb begin
    timeout = (state_q == WAIT) && !dmem_ack && (cnt_q == CNT_W'(DMEM_TIMEOUT - 1));
    cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    err_d   = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dmem_err = err_q;
`else
  assign timeout  = 1'b0;
  assign dmem_err = 1'b0;
`endif

  always_comb begin
    mem_op     = M_MemRead | M_MemWrite;
    dmem_req   = (state_q == WAIT) | mem_op;
    dmem_we    = dmem_req & M_MemWrite;
    dmem_addr  = M_ALUout;
    dmem_wdata = M_sw ? M_WriteData : {M_WriteData[7:0], M_WriteData[7:0]};
    done       = (dmem_req & dmem_ack) | timeout;
    stall      = dmem_req & ~done;

    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op && !dmem_ack) state_d = WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A forced completion must not expose whatever is on the read bus.
    rdata_eff = timeout ? '0 : dmem_rdata;
    case (wb_select(M_Pcs, M_MemtoReg, M_load_byte))
      WB_PC:   wb_val = M_Nxt_Pc;
      WB_BYTE: wb_val = {8'h00, M_ALUout[0] ? rdata_eff[7:0] : rdata_eff[15:8]};
      WB_MEM:  wb_val = rdata_eff;
      default: wb_val = M_ALUout;
    endcase

    // A pure store never writes a register; read+write keeps M_RegWrite.
    regwrite = M_RegWrite & ~(M_MemWrite & ~M_MemRead);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (stall),
    .d_dest       (M_Destination),
    .d_wdata      (wb_val),
    .d_regwrite   (regwrite),
    .d_hlt        (M_hlt),
    .W_Destination(W_Destination),
    .W_WriteData  (W_WriteData),
    .W_RegWrite   (W_RegWrite),
    .W_hlt        (W_hlt)
  );
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its M_* outputs.
- Performs data-memory loads and stores over a variable-latency request/acknowledge interface, and stalls the front of the pipe while an access is outstanding.
- Selects the writeback value and registers everything into the MEM/WB boundary as W_* outputs.

Parameters:
- DMEM_TIMEOUT, 64, cycles waited for dmem_ack before a forced completion (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- M_Destination  in  4  destination register
- M_ALUout  in  16  ALU result; memory address for loads/stores
- M_WriteData  in  16  store data
- M_Nxt_Pc  in  16  PC+2 (for PCS)
- M_hlt, M_MemtoReg, M_MemRead, M_MemWrite, M_RegWrite, M_Pcs, M_load_byte, M_sw  in  1 each  control signals
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  16  byte address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete
- stall  out  1  hold IF/ID, ID/EX and EX/MEM; insert no new op
- W_Destination  out  4  registered
- W_WriteData  out  16  registered writeback value
- W_RegWrite, W_hlt  out  1 each  registered
- dmem_err  out  1  sticky timeout flag (0 when the feature is compiled out)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n. All state updates occur at posedge clk.
  - When rst_n=0 at a posedge: FSM goes to IDLE; W_Destination=0, W_WriteData=0x0000, W_RegWrite=0, W_hlt=0, dmem_err=0.
  - dmem_req, dmem_we and stall are combinational from state and inputs, so they are 0 in IDLE with no memory op.
  - A reset mid-access abandons the access. Any later dmem_ack is ignored.
- Memory op: mem_op = M_MemRead | M_MemWrite.
- FSM states: IDLE, WAIT.
- IDLE, mem_op=0:
  - Single-cycle pass-through into the W_* registers.
  - No request is issued and stall=0.
- IDLE, mem_op=1:
  - dmem_req=1, dmem_we=M_MemWrite, dmem_addr=M_ALUout, dmem_wdata=M_WriteData.
  - If dmem_ack=1 in the same cycle (zero-wait), the op completes, W is updated and stall=0.
  - Otherwise stall=1 and the next state is WAIT.
- WAIT:
  - dmem_req and dmem_we stay asserted. The address and data are taken from the M_* inputs, which upstream holds stable because stall=1.
  - Each cycle without dmem_ack: stall=1 and a bubble is written to W (W_RegWrite=0, W_hlt=0; other W fields don't-care, driven to 0).
  - On dmem_ack: complete, stall=0, W is updated, next state is IDLE.
- dmem_ack while no request is active is ignored.
- Writeback select, in priority order:
  - M_Pcs → M_Nxt_Pc
  - M_MemtoReg & M_load_byte → zero-extended byte, dmem_rdata[15:8] if M_ALUout[0]=0, else dmem_rdata[7:0] (big-endian)
  - M_MemtoReg → dmem_rdata
  - otherwise → M_ALUout
- Stores:
  - M_sw marks a word store. M_MemWrite=1 with M_sw=0 is a byte store and is not supported by the DMEM interface.
  - For a byte store, dmem_we=1 is still issued with dmem_wdata={M_WriteData[7:0], M_WriteData[7:0]}. Byte-lane masking is the memory's responsibility.
  - A store sets W_RegWrite=0 regardless of M_RegWrite.
- M_hlt is registered to W_hlt only on completion; it never escapes early during a stall.
- Simultaneous M_MemRead and M_MemWrite: treated as a write, and W_RegWrite takes M_RegWrite.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter (clog2(DMEM_TIMEOUT)+1 bits) is cleared on entry to WAIT and incremented each WAIT cycle.
  - When it reaches DMEM_TIMEOUT with no ack, the op force-completes: a load returns 0x0000, dmem_err is set sticky until reset, and the FSM returns to IDLE.
- Undefined: no counter; WAIT lasts indefinitely; dmem_err is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - state enum {IDLE, WAIT}
  - WORD_W=16, REG_ADDR_W=4
  - writeback-select constants
- One sub-module: mem_wb_reg, holding the W_* flops with synchronous active-low reset and bubble insertion.

Test Plan:
- ALU op, M_ALUout=0x1234, M_RegWrite=1, M_Destination=3 → next cycle W_WriteData=0x1234, W_RegWrite=1, W_Destination=3, stall=0, dmem_req=0.
- Word load from 0x0040, ack after 3 cycles, rdata=0xBEEF → stall=1 for 3 cycles with bubbles on W, then W_WriteData=0xBEEF and W_RegWrite=1.
- Byte load from 0x0041, zero-wait ack, rdata=0xA55A → W_WriteData=0x005A. Repeat at 0x0040 → W_WriteData=0x00A5.
- Word store to 0x0010, data 0xCAFE → dmem_we=1, dmem_wdata=0xCAFE, W_RegWrite=0. A PCS op with Nxt_Pc=0x0022 → W_WriteData=0x0022.
- Reset asserted in WAIT, then ack arrives → all W outputs 0, state IDLE, late ack produces no W update.
- With DMEM_TIMEOUT_EN and DMEM_TIMEOUT=4, a load with no ack → completes after 4 WAIT cycles, W_WriteData=0x0000, dmem_err=1 and held.
